// File: rtl/flash_sr_writer.sv
// flash_sr_writer: WREN, WRSR, then RDSR polling until WIP clears, on raw SPI pins.
// Define FLASH_SR_VERIFY_EN to flag err when the final status differs from SR_DATA under SR_MASK.
module flash_sr_writer #(
  parameter logic [7:0] SR_DATA  = 8'h9C,
  parameter logic [7:0] SR_MASK  = 8'hFC,
  parameter int         HALF     = 1,
  parameter int         POLL_MAX = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  output logic       rdy,
  output logic       err,
  output logic [7:0] sr_rd,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_clk,
  output logic       spi_cs_n
);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [HW-1:0] H_END = HW'(HALF - 1);
  localparam logic [PW-1:0] P_END = PW'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_WRSR, S_RDSR, S_CHECK
  } seq_t;

  typedef enum logic [2:0] {
    F_IDLE, F_SETUP, F_SHIFT, F_HOLD, F_GAP
  } ph_t;

  seq_t seq_q, seq_d, nxt;
  ph_t ph_q, ph_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0] bcnt_q, bcnt_d, last;
  logic [2:0] gcnt_q, gcnt_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, sr_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic two_q, two_d, launch, mismatch;
  logic rdy_d, err_d, mosi_d, sclk_d, cs_d;

`ifdef FLASH_SR_VERIFY_EN
  assign mismatch = (sr_rd & SR_MASK) != (SR_DATA & SR_MASK);
`else
  assign mismatch = &{1'b0, SR_MASK};
`endif

  assign last = two_q ? 4'd15 : 4'd7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q    <= S_IDLE;
      ph_q     <= F_IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      gcnt_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      two_q    <= 1'b0;
      pcnt_q   <= '0;
      rdy      <= 1'b1;
      err      <= 1'b0;
      sr_rd    <= 8'h00;
      spi_mosi <= 1'b0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      seq_q    <= seq_d;
      ph_q     <= ph_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      gcnt_q   <= gcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      two_q    <= two_d;
      pcnt_q   <= pcnt_d;
      rdy      <= rdy_d;
      err      <= err_d;
      sr_rd    <= sr_d;
      spi_mosi <= mosi_d;
      spi_clk  <= sclk_d;
      spi_cs_n <= cs_d;
    end
  end

  always_comb begin
    seq_d  = seq_q;
    ph_d   = ph_q;
    hcnt_d = hcnt_q;
    bcnt_d = bcnt_q;
    gcnt_d = gcnt_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    two_d  = two_q;
    pcnt_d = pcnt_q;
    rdy_d  = rdy;
    err_d  = err;
    sr_d   = sr_rd;
    mosi_d = spi_mosi;
    sclk_d = spi_clk;
    cs_d   = spi_cs_n;
    launch = 1'b0;
    nxt    = seq_q;
    if (seq_q == S_IDLE && go) begin
      seq_d  = S_WREN;
      rdy_d  = 1'b0;
      err_d  = 1'b0;
      pcnt_d = '0;
    end
    unique case (ph_q)
      F_IDLE: begin
        if (seq_q == S_WREN) launch = 1'b1;
      end
      F_SETUP: begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_q == H_END) begin
          hcnt_d = '0;
          ph_d   = F_SHIFT;
        end
      end
      F_SHIFT: begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_q == H_END) begin
          hcnt_d = '0;
          if (!spi_clk) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[14:0], tx_q[15]};
            mosi_d = tx_q[14];
            bcnt_d = bcnt_q + 4'd1;
            if (bcnt_q == last) begin
              ph_d   = F_HOLD;
              mosi_d = 1'b0;
            end
          end
        end
      end
      F_HOLD: begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_q == H_END) begin
          hcnt_d = '0;
          cs_d   = 1'b1;
          ph_d   = F_GAP;
          gcnt_d = '0;
          if (seq_q == S_RDSR) begin
            sr_d   = rx_q;
            pcnt_d = pcnt_q + PW'(1);
            seq_d  = S_CHECK;
          end
        end
      end
      F_GAP: begin
        gcnt_d = gcnt_q + 3'd1;
        if (gcnt_q == 3'd7) begin
          ph_d = F_IDLE;
          unique case (seq_q)
            S_WREN: begin
              launch = 1'b1;
              nxt    = S_WRSR;
            end
            S_WRSR: begin
              launch = 1'b1;
              nxt    = S_RDSR;
            end
            S_CHECK: begin
              if (sr_rd[0] && pcnt_q != P_END) begin
                launch = 1'b1;
                nxt    = S_RDSR;
              end else begin
                seq_d = S_IDLE;
                rdy_d = 1'b1;
                err_d = sr_rd[0] | mismatch;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    // next frame starts straight out of the gap so gaps stay exactly 8 cycles
    if (launch) begin
      seq_d  = nxt;
      ph_d   = F_SETUP;
      cs_d   = 1'b0;
      sclk_d = 1'b0;
      hcnt_d = '0;
      bcnt_d = '0;
      two_d  = (nxt != S_WREN);
      unique case (1'b1)
        nxt == S_WREN: tx_d = {8'h06, 8'h00};
        nxt == S_WRSR: tx_d = {8'h01, SR_DATA};
        default:       tx_d = {8'h05, 8'h00};
      endcase
      mosi_d = tx_d[15];
    end
  end
endmodule

// File: tb/tb_flash_sr_writer.sv
// Bench for flash_sr_writer: flash model with scripted status bytes,
// SPI frame monitor and a poll/verify reference model.
module tb_flash_sr_writer;
  localparam logic [7:0] SR   = 8'h9C;
  localparam logic [7:0] MASK = 8'hFC;
  localparam int         PMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0;
  logic spi_miso = 1'b0;
  logic rdy, err, spi_mosi, spi_clk, spi_cs_n;
  logic [7:0] sr_rd;
  int n_cmp = 0;
  int n_bad = 0;

  flash_sr_writer #(
    .SR_DATA(SR), .SR_MASK(MASK), .HALF(1), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .rdy(rdy), .err(err),
    .sr_rd(sr_rd), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  logic [7:0]  st_q[$];
  logic [31:0] frm_q[$];
  int low_q[$];
  int gap_q[$];
  int low_cnt, hi_cnt, bits, rdy_gap;
  int frame_starts = 0;
  logic [15:0] shreg;
  logic [7:0] cur_st;
  logic is_rd = 1'b0;
  logic have_prev = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_rdy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flash side: decode mosi, serve status bytes on RDSR data phase
  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b1;
      bits = 0;
      is_rd = 1'b0;
      spi_miso = 1'b0;
      low_cnt = 0;
      hi_cnt = 0;
    end else if (!spi_cs_n) begin
      if (prev_cs) begin
        if (have_prev) gap_q.push_back(hi_cnt);
        frame_starts++;
        low_cnt = 0;
        bits = 0;
        shreg = '0;
        is_rd = 1'b0;
      end
      low_cnt++;
      if (!prev_sclk && spi_clk) begin
        shreg = {shreg[14:0], spi_mosi};
        bits++;
        if (bits == 8 && shreg[7:0] == 8'h05) begin
          is_rd = 1'b1;
          cur_st = (st_q.size() > 0) ? st_q.pop_front() : 8'hFF;
        end
      end
      spi_miso = 1'b0;
      if (is_rd && bits >= 8 && bits < 16)
        spi_miso = cur_st[3'(15 - bits)];
    end else begin
      if (!prev_cs) begin
        frm_q.push_back({16'(bits), shreg});
        low_q.push_back(low_cnt);
        hi_cnt = 0;
        have_prev = 1'b1;
      end
      if (rdy && !prev_rdy) rdy_gap = hi_cnt;
      hi_cnt++;
      spi_miso = 1'b0;
    end
    prev_cs = spi_cs_n;
    prev_sclk = spi_clk;
    prev_rdy = rdy;
  end

  task automatic wait_wrsr(input string tag);
    int i;
    for (i = 0; i < 500; i++) begin
      if (frame_starts == 2 && bits >= 4) break;
      @(negedge clk);
    end
    check({tag, ":reach_wrsr"}, 32'(i < 500), 1);
    @(negedge clk);
  endtask

  task automatic run_seq(input string tag, input bit mid_go);
    logic [7:0] s, e_sr;
    logic [31:0] e_frm;
    logic e_err;
    int polls, k;
    bit done;
    polls = 0;
    k = 0;
    e_err = 1'b0;
    e_sr = 8'h00;
    done = 1'b0;
    while (!done) begin
      s = (k < st_q.size()) ? st_q[k] : 8'hFF;
      k++;
      polls++;
      e_sr = s;
      if (!s[0]) begin
        done = 1'b1;
`ifdef FLASH_SR_VERIFY_EN
        e_err = ((s ^ SR) & MASK) != 8'h00;
`endif
      end else if (polls == PMAX) begin
        done = 1'b1;
        e_err = 1'b1;
      end
    end
    frm_q.delete();
    low_q.delete();
    gap_q.delete();
    have_prev = 1'b0;
    frame_starts = 0;
    rdy_gap = -1;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check({tag, ":rdy_fall"}, rdy, 0);
    check({tag, ":cs_still_high"}, spi_cs_n, 1);
    @(negedge clk);
    check({tag, ":cs_fall"}, spi_cs_n, 0);
    if (mid_go) begin
      wait_wrsr(tag);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    for (int i = 0; i < 3000 && !rdy; i++) @(negedge clk);
    #1;
    check({tag, ":rdy_done"}, rdy, 1);
    check({tag, ":err"}, err, e_err);
    check({tag, ":sr_rd"}, sr_rd, e_sr);
    check({tag, ":n_frames"}, frm_q.size(), 2 + polls);
    for (int i = 0; i < frm_q.size() && i < 2 + polls; i++) begin
      e_frm = (i == 0) ? 32'h0008_0006 :
              (i == 1) ? {16'd16, 8'h01, SR} : 32'h0010_0500;
      check($sformatf("%s:frame%0d", tag, i), frm_q[i], e_frm);
      check($sformatf("%s:cs_low%0d", tag, i), low_q[i], (i == 0) ? 18 : 34);
    end
    check({tag, ":n_gaps"}, gap_q.size(), 1 + polls);
    for (int i = 0; i < gap_q.size(); i++)
      check($sformatf("%s:gap%0d", tag, i), gap_q[i], 8);
    check({tag, ":rdy_gap"}, rdy_gap, 8);
    st_q.delete();
  endtask

  initial begin
    int act, nb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst:rdy", rdy, 1);
    check("rst:err", err, 0);
    check("rst:cs_n", spi_cs_n, 1);
    check("rst:sclk", spi_clk, 0);
    check("rst:mosi", spi_mosi, 0);
    check("rst:sr_rd", sr_rd, 0);
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (!spi_cs_n || spi_clk || spi_mosi) act++;
    end
    check("rst:idle_activity", act, 0);

    st_q = '{8'h03, 8'h03, 8'h9C};
    run_seq("nominal", 1'b0);
    run_seq("timeout", 1'b0);
    st_q = '{8'h80};
    run_seq("verify", 1'b0);
    st_q = '{8'h01, 8'h9C};
    run_seq("busy_go", 1'b1);

    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(0, 5);
      for (int j = 0; j < nb; j++) st_q.push_back(8'($urandom) | 8'h01);
      case ($urandom_range(0, 2))
        0: st_q.push_back(SR);
        1: st_q.push_back(8'($urandom) & 8'hFE);
        default: st_q.push_back(SR | 8'h02);
      endcase
      run_seq($sformatf("rand%0d", r), 1'b0);
    end

    st_q.delete();
    frame_starts = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_wrsr("rst_mid");
    #2 rst = 1'b1;
    #1;
    check("rst_mid:cs_n", spi_cs_n, 1);
    check("rst_mid:sclk", spi_clk, 0);
    check("rst_mid:rdy", rdy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid:rdy_after", rdy, 1);
    check("rst_mid:sr_rd", sr_rd, 0);
    st_q = '{8'h00};
    run_seq("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
